// File: rtl/dcache_miss_ctrl_if.sv
// Bus bundle for dcache_miss_ctrl: the MEM-stage request/response plus the word-beat memory port.
// The master side is the pipeline plus memory; the slave side is the cache controller.
interface dcache_miss_ctrl_if;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output rd_req, wr_req, addr, wr_data, mem_rdata, mem_ack,
    input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rd_req, wr_req, addr, wr_data, mem_rdata, mem_ack,
    output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped write-back/write-allocate data cache with word-by-word evict and refill FSM.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module dcache_miss_ctrl #(
  parameter int unsigned LINE_ADDR_LEN = 2,
  parameter int unsigned SET_ADDR_LEN  = 3
) (
  input logic               clk,
  input logic               rst,
  dcache_miss_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  localparam int unsigned TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int unsigned LINE_WORDS   = 1 << LINE_ADDR_LEN;
  localparam int unsigned SETS         = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {StIdle, StWb, StRefill} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]          valid_q;
  logic [SETS-1:0]          dirty_q;
  logic [TAG_ADDR_LEN-1:0]  tag_q  [SETS];
  logic [31:0]              data_q [SETS][LINE_WORDS];
  logic [LINE_ADDR_LEN-1:0] cnt_q;
  logic [TAG_ADDR_LEN-1:0]  victim_tag_q;

  logic [LINE_ADDR_LEN-1:0] req_word;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [TAG_ADDR_LEN-1:0]  req_tag;
  logic                     req;
  logic                     hit;
  logic                     cnt_last;
  logic                     unused_addr;

  assign req_word    = bus.addr[2 +: LINE_ADDR_LEN];
  assign req_set     = bus.addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign req_tag     = bus.addr[31 -: TAG_ADDR_LEN];
  assign unused_addr = ^bus.addr[1:0];
  assign req         = bus.rd_req | bus.wr_req;
  assign hit         = valid_q[req_set] && (tag_q[req_set] == req_tag);
  assign cnt_last    = (cnt_q == {LINE_ADDR_LEN{1'b1}});

  always_comb begin
    state_d       = state_q;
    bus.miss      = 1'b0;
    bus.rd_data   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        bus.rd_data = hit ? data_q[req_set][req_word] : '0;
        if (req && !hit) begin
          bus.miss = 1'b1;
          state_d  = dirty_q[req_set] ? StWb : StRefill;
        end
      end
      StWb: begin
        bus.miss      = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {victim_tag_q, req_set, cnt_q, 2'b00};
        bus.mem_wdata = data_q[req_set][cnt_q];
        if (bus.mem_ack && cnt_last) state_d = StRefill;
      end
      StRefill: begin
        bus.miss     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, req_set, cnt_q, 2'b00};
        if (bus.mem_ack && cnt_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state: reset discards any line mid-eviction or mid-refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (bus.wr_req && hit) dirty_q[req_set] <= 1'b1;
          if (req && !hit) cnt_q <= '0;
        end
        StWb: begin
          if (bus.mem_ack) begin
            cnt_q <= cnt_q + LINE_ADDR_LEN'(1);
            if (cnt_last) dirty_q[req_set] <= 1'b0;
          end
        end
        StRefill: begin
          if (bus.mem_ack) begin
            cnt_q <= cnt_q + LINE_ADDR_LEN'(1);
            if (cnt_last) begin
              valid_q[req_set] <= 1'b1;
              dirty_q[req_set] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Array contents need no reset; validity lives in valid_q.
  always_ff @(posedge clk) begin
    unique case (state_q)
      StIdle: begin
        if (bus.wr_req && hit) data_q[req_set][req_word] <= bus.wr_data;
        if (req && !hit) victim_tag_q <= tag_q[req_set];
      end
      StRefill: begin
        if (bus.mem_ack) begin
          data_q[req_set][cnt_q] <= bus.mem_rdata;
          if (cnt_last) tag_q[req_set] <= req_tag;
        end
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StIdle && req) begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
